alu_exec_pipe: RTL
==================

// Module: alu_exec_pipe
// PURPOSE
//  Parametrised two-stage ALU execute unit: stage 1 decodes ALUOp/FuncCode into a 4-bit ALU control code,
//  stage 2 computes a WIDTH-bit result. Valid/ready handshake on both sides, full-throughput back-pressure.
//  Sits between register read and writeback in the RV datapath; also counts illegal-op encodings.
// PARAMETERS
//  WIDTH      32  operand/result width in bits (>= 8)
//  CNT_W       8  width of the saturating illegal-op counter
// PORTS
//  clk          in   1        clock, all state on rising edge
//  reset        in   1        synchronous, active-high reset
//  in_valid     in   1        operation presented
//  in_ready     out  1        unit accepts operation this cycle
//  alu_op       in   2        ALUOp from main control
//  func_code    in   10       {I[30],I[25],..} funct bits; bit8 = I[30], bits2:0 = funct3
//  op_a, op_b   in   WIDTH    operands
//  out_valid    out  1        result valid
//  out_ready    in   1        consumer accepts result
//  result       out  WIDTH    ALU result
//  zero         out  1        result == 0
//  illegal      out  1        operation was an undefined encoding
//  alu_ctrl     out  4        decoded control code carried with result
//  illegal_cnt  out  CNT_W    saturating count of illegal ops delivered
// BEHAVIOUR
//  - Decode (alu_op, func_code -> alu_ctrl): 00,any->0010 ADD; 10,0->0010 ADD; 10,256->0110 SUB;
//    10,2->0111 SLT; 01,7->0000 AND; 01,1->0001 OR; 01,263->1100 NOR; all else->1111 ILLEGAL.
//  - Execute: ADD/SUB modulo 2^WIDTH, carry/overflow discarded; SLT signed two's-complement, result 1 or 0
//    zero-extended; NOR = ~(a|b). ILLEGAL: result=0, illegal=1, zero=1.
//  - Pipeline: s1 reg {ctrl, a, b, valid}; s2 reg {result, zero, illegal, ctrl, valid}. Latency 2 cycles
//    from accepting edge to out_valid when unstalled; throughput 1 op/cycle.
//  - Stall rule: s2 advances when !s2_valid || out_ready; s1 advances when !s1_valid || s2 advances.
//    in_ready = !s1_valid || s2_adv (combinational). Accept on in_valid && in_ready.
//  - out_valid held, outputs stable, while out_valid && !out_ready. No bubble insertion when full and draining.
//  - illegal_cnt increments on out_valid && out_ready && illegal; saturates at 2^CNT_W-1, no wrap.
//  - Reset: s1/s2 valid=0, out_valid=0, result=0, zero=0, illegal=0, alu_ctrl=0000, illegal_cnt=0;
//    in_ready=1 the cycle after reset deasserts. Reset mid-flight discards both stages, no output emitted.
//  - Simultaneous accept and deliver with both stages full: all three move; no loss, no duplication.
// CONFIGURATION
//  ALU_SHIFT_EN defined: adds 10,1->0011 SLL; 10,5->0100 SRL; 10,261->0101 SRA; shift amount
//    op_b[$clog2(WIDTH)-1:0], upper op_b bits ignored; SRA sign-fills.
//  ALU_SHIFT_EN undefined: those encodings decode to 1111 ILLEGAL and count as illegal.
// TESTING
//  1) reset, out_ready=1; ADD a=5 b=7 (00) -> 2 cycles later result=12, alu_ctrl=0010, zero=0.
//  2) SUB 10/256 a=3 b=3 -> result=0, zero=1; SLT 10/2 a=-1 b=1 -> result=1; a=1 b=-1 -> 0.
//  3) back-to-back AND(01/7) 0xF0F0&0xFF00, OR(01/1), NOR(01/263) a=0 b=0 -> 0xF000, OR value, all-ones,
//     consecutive cycles, in_ready held 1.
//  4) out_ready=0 for 4 cycles with streaming input -> in_ready drops after 2 accepts, result held stable;
//     release -> 2 queued results in order, none lost or duplicated.
//  5) alu_op=11 x(2^CNT_W+1) -> illegal=1, result=0, illegal_cnt saturates at 255 (CNT_W=8);
//     reset asserted with both stages full -> out_valid=0 next cycle, counter=0.
//  6) ALU_SHIFT_EN: SRA 10/261 a=0x80000000 b=4 -> 0xF8000000; without macro same op -> illegal=1.

Source files
------------

// File: rtl/alu_exec_pipe.sv
// Two-stage ALU execute unit: stage 1 decodes ALUOp/funct to a control code, stage 2 computes the result.
// Optional shift operations are enabled by defining ALU_SHIFT_EN.
module alu_exec_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [9:0]       func_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [3:0]       alu_ctrl,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int SH_W = $clog2(WIDTH);

`ifdef ALU_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SLL = 4'b0011;
    localparam logic [3:0] CTRL_SRL = 4'b0100;
    localparam logic [3:0] CTRL_SRA = 4'b0101;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;
    localparam logic [3:0] CTRL_ILL = 4'b1111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [3:0] decode_ctrl(input logic [1:0] op, input logic [9:0] fc);
        logic [3:0] c;
        c = CTRL_ILL;
        case (op)
            2'b00: c = CTRL_ADD;
            2'b10: begin
                case (fc)
                    10'd0:   c = CTRL_ADD;
                    10'd256: c = CTRL_SUB;
                    10'd2:   c = CTRL_SLT;
                    10'd1:   c = SHIFT_EN ? CTRL_SLL : CTRL_ILL;
                    10'd5:   c = SHIFT_EN ? CTRL_SRL : CTRL_ILL;
                    10'd261: c = SHIFT_EN ? CTRL_SRA : CTRL_ILL;
                    default: c = CTRL_ILL;
                endcase
            end
            2'b01: begin
                case (fc)
                    10'd7:   c = CTRL_AND;
                    10'd1:   c = CTRL_OR;
                    10'd263: c = CTRL_NOR;
                    default: c = CTRL_ILL;
                endcase
            end
            default: c = CTRL_ILL;
        endcase
        return c;
    endfunction

    // Illegal and unknown codes yield zero, which also makes the zero flag true for them.
    function automatic logic [WIDTH-1:0] exec_alu(input logic [3:0] ctrl,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic [SH_W-1:0]  sh;
        sh = b[SH_W-1:0];
        r  = {WIDTH{1'b0}};
        case (ctrl)
            CTRL_ADD: r = a + b;
            CTRL_SUB: r = a - b;
            CTRL_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            CTRL_AND: r = a & b;
            CTRL_OR:  r = a | b;
            CTRL_NOR: r = ~(a | b);
            CTRL_SLL: r = a << sh;
            CTRL_SRL: r = a >> sh;
            CTRL_SRA: r = $signed(a) >>> sh;
            default:  r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    logic             s1_valid_r;
    logic [3:0]       s1_ctrl_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_result_r;
    logic             s2_zero_r;
    logic             s2_illegal_r;
    logic [3:0]       s2_ctrl_r;
    logic [CNT_W-1:0] illegal_cnt_r;
    logic             s2_adv_s;
    logic             s1_adv_s;
    logic [WIDTH-1:0] exec_res_s;

    // Back-pressure chain: a stage moves when it is empty or the stage ahead of it moves.
    always_comb begin
        s2_adv_s   = !s2_valid_r || out_ready;
        s1_adv_s   = !s1_valid_r || s2_adv_s;
        exec_res_s = exec_alu(s1_ctrl_r, s1_a_r, s1_b_r);
    end

    // Stage 1: decode and capture operands on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_ctrl_r  <= 4'b0000;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_ctrl_r <= decode_ctrl(alu_op, func_code);
                s1_a_r    <= op_a;
                s1_b_r    <= op_b;
            end
        end
    end

    // Stage 2: execute and hold the result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_r   <= 1'b0;
            s2_result_r  <= {WIDTH{1'b0}};
            s2_zero_r    <= 1'b0;
            s2_illegal_r <= 1'b0;
            s2_ctrl_r    <= 4'b0000;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_result_r  <= exec_res_s;
                s2_zero_r    <= (exec_res_s == {WIDTH{1'b0}});
                s2_illegal_r <= (s1_ctrl_r == CTRL_ILL);
                s2_ctrl_r    <= s1_ctrl_r;
            end
        end
    end

    // Saturating count of illegal results actually handed to the consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_cnt_r <= {CNT_W{1'b0}};
        end else if (s2_valid_r && out_ready && s2_illegal_r && (illegal_cnt_r != CNT_MAX)) begin
            illegal_cnt_r <= illegal_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready    = s1_adv_s;
    assign out_valid   = s2_valid_r;
    assign result      = s2_result_r;
    assign zero        = s2_zero_r;
    assign illegal     = s2_illegal_r;
    assign alu_ctrl    = s2_ctrl_r;
    assign illegal_cnt = illegal_cnt_r;

endmodule
